// File: rtl/adc_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc_sample_ctrl
// Brief    : Paced ADC conversion requester with 4-phase req/rdy handshake,
//            sample counting, handshake timeout and overrun flags.
// Revision : 1.0
// ============================================================================
module adc_sample_ctrl #(
    parameter int DATA_W  = 8,
    parameter int DIV     = 4,
    parameter int TIMEOUT = 16,
    parameter int RST_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_err_clr,
    input  logic              i_adc_rdy,
    input  logic [DATA_W-1:0] i_adc_dat,
    output logic              o_adc_req,
    output logic              o_adc_rst,
    output logic [DATA_W-1:0] o_smp_dat,
    output logic              o_smp_vld,
    output logic [31:0]       o_smp_cnt,
    output logic              o_busy,
    output logic              o_err_to,
    output logic              o_ovr
);

    localparam int c_DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_RC_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_RC_W-1:0]  c_RC_LAST  = c_RC_W'(RST_CYC - 1);

    typedef enum logic [1:0] {
        ST_ARST    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_REQ     = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_DIV_W-1:0]  r_div_cnt;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [c_RC_W-1:0]   r_rst_cnt;
    logic                r_adc_req;
    logic                r_adc_rst;
    logic [DATA_W-1:0]   r_smp_dat;
    logic                r_smp_vld;
    logic [31:0]         r_smp_cnt;
    logic                r_busy;
    logic                r_err_to;
    logic                r_ovr;
    logic                w_tick;

    assign w_tick = i_en && (r_div_cnt == c_DIV_LAST);

    // Divider is held at zero while disabled so re-enabling gives a full period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (!i_en || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_ARST;
            r_to_cnt  <= '0;
            r_rst_cnt <= '0;
            r_adc_req <= 1'b0;
            r_adc_rst <= 1'b1;
            r_smp_dat <= '0;
            r_smp_vld <= 1'b0;
            r_smp_cnt <= '0;
            r_busy    <= 1'b1;
            r_err_to  <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_smp_vld <= 1'b0;

            if (w_tick && (r_state != ST_IDLE)) begin
                r_ovr <= 1'b1;
            end else if (i_err_clr) begin
                r_ovr <= 1'b0;
            end

            // A timeout raised below overrides this clear in the same cycle.
            if (i_err_clr) begin
                r_err_to <= 1'b0;
            end

            case (r_state)
                ST_ARST: begin
                    if (r_rst_cnt == c_RC_LAST) begin
                        r_adc_rst <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_tick) begin
                        r_adc_req <= 1'b1;
                        r_to_cnt  <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_adc_rdy) begin
                        r_smp_dat <= i_adc_dat;
                        r_smp_vld <= 1'b1;
                        r_smp_cnt <= r_smp_cnt + 32'd1;
                        r_adc_req <= 1'b0;
                        r_to_cnt  <= '0;
                        r_state   <= ST_WAIT_LO;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_adc_req <= 1'b0;
                        r_err_to  <= 1'b1;
                        r_adc_rst <= 1'b1;
                        r_rst_cnt <= '0;
                        r_state   <= ST_ARST;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_WAIT_LO: begin
                    if (!i_adc_rdy) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_err_to  <= 1'b1;
                        r_adc_rst <= 1'b1;
                        r_rst_cnt <= '0;
                        r_state   <= ST_ARST;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: begin
                    r_adc_req <= 1'b0;
                    r_adc_rst <= 1'b1;
                    r_rst_cnt <= '0;
                    r_busy    <= 1'b1;
                    r_state   <= ST_ARST;
                end
            endcase
        end
    end

    assign o_adc_req = r_adc_req;
    assign o_adc_rst = r_adc_rst;
    assign o_smp_dat = r_smp_dat;
    assign o_smp_vld = r_smp_vld;
    assign o_smp_cnt = r_smp_cnt;
    assign o_busy    = r_busy;
    assign o_err_to  = r_err_to;
    assign o_ovr     = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_sample_ctrl
// Brief    : Directed scoreboard bench for adc_sample_ctrl with ADC responders.
// Revision : 1.0
// ============================================================================
module tb_adc_sample_ctrl;

    typedef struct packed {
        logic [7:0]  dat;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en1, en2, err_clr;
    logic        rdy1, rdy2;
    logic [7:0]  adat1, adat2;
    logic        req1, rst1, vld1, busy1, eto1, ovr1;
    logic        req2, rst2, vld2, busy2, eto2, ovr2;
    logic [7:0]  sdat1, sdat2;
    logic [31:0] cnt1, cnt2;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_vld1 = 0, n_vld2 = 0, n_hs2 = 0;
    int          lat1, lc1, lc2;
    logic        dead1, spur1, fix_dat;
    logic [31:0] exp_cnt1, last_cnt2;
    exp_t        q1[$];

    always #5 clk = ~clk;

    adc_sample_ctrl #(.DATA_W(8), .DIV(4), .TIMEOUT(16), .RST_CYC(4)) u_dut1 (
        .clk(clk), .reset(reset), .i_en(en1), .i_err_clr(err_clr),
        .i_adc_rdy(rdy1), .i_adc_dat(adat1), .o_adc_req(req1), .o_adc_rst(rst1),
        .o_smp_dat(sdat1), .o_smp_vld(vld1), .o_smp_cnt(cnt1), .o_busy(busy1),
        .o_err_to(eto1), .o_ovr(ovr1)
    );

    adc_sample_ctrl #(.DATA_W(8), .DIV(2), .TIMEOUT(16), .RST_CYC(4)) u_dut2 (
        .clk(clk), .reset(reset), .i_en(en2), .i_err_clr(err_clr),
        .i_adc_rdy(rdy2), .i_adc_dat(adat2), .o_adc_req(req2), .o_adc_rst(rst2),
        .o_smp_dat(sdat2), .o_smp_vld(vld2), .o_smp_cnt(cnt2), .o_busy(busy2),
        .o_err_to(eto2), .o_ovr(ovr2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // DUT1: scoreboard monitor followed by the ADC responder (same block, no race)
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            rdy1 = 1'b0;
            lc1  = 0;
        end else begin
            if (vld1) begin
                n_vld1++;
                if (q1.size() == 0) begin
                    chk("vld_unexpected", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("smp_dat", sdat1, e.dat);
                    chk("smp_cnt", cnt1, e.cnt);
                end
            end
            if (rdy1) chk("req_while_rdy", req1, 0);
            if (!req1) begin
                lc1  = 0;
                rdy1 = spur1;
            end else if (!rdy1 && !dead1) begin
                lc1++;
                if (lc1 >= lat1) begin
                    rdy1     = 1'b1;
                    adat1    = fix_dat ? 8'hA7 : 8'($urandom);
                    exp_cnt1 = exp_cnt1 + 32'd1;
                    q1.push_back({adat1, exp_cnt1});
                end
            end
        end
    end

    // DUT2: fixed 3-cycle ADC, strobe count and gap-free sequence tracking
    always @(negedge clk) begin
        if (reset) begin
            rdy2      = 1'b0;
            lc2       = 0;
            last_cnt2 = '0;
        end else begin
            if (vld2) begin
                n_vld2++;
                chk("cnt2_seq", cnt2, last_cnt2 + 32'd1);
                last_cnt2 = cnt2;
            end
            if (!req2) begin
                lc2  = 0;
                rdy2 = 1'b0;
            end else if (!rdy2) begin
                lc2++;
                if (lc2 >= 3) begin
                    rdy2  = 1'b1;
                    adat2 = 8'($urandom);
                    n_hs2++;
                end
            end
        end
    end

    task automatic wait_vld(input int k, input int budget);
        int tgt = n_vld1 + k;
        int i = 0;
        while (n_vld1 < tgt && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("wait_vld_timeout", n_vld1 >= tgt, 1);
    endtask

    task automatic wait_idle1();
        int i = 0;
        while ((busy1 || q1.size() != 0) && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("idle1_timeout", busy1, 0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        en1 = 0; en2 = 0; err_clr = 0; lat1 = 2; dead1 = 0; spur1 = 0;
        fix_dat = 1; exp_cnt1 = '0; adat1 = '0; adat2 = '0; rdy1 = 0; rdy2 = 0;
        repeat (2) @(negedge clk);
        chk("rst_adc_req", req1, 0);
        chk("rst_adc_rst", rst1, 1);
        chk("rst_smp_dat", sdat1, 0);
        chk("rst_smp_vld", vld1, 0);
        chk("rst_smp_cnt", cnt1, 0);
        chk("rst_busy", busy1, 1);
        chk("rst_err_to", eto1, 0);
        chk("rst_ovr", ovr1, 0);

        // First sample after reset release, ADC answers after 2 cycles
        en1 = 1; reset = 0;
        n = 0;
        while (rst1 && n < 20) begin n++; @(negedge clk); end
        chk("arst_cycles", n, 4);
        wait_vld(1, 60);
        en1 = 0;
        chk("t1_dat", sdat1, 8'hA7);
        chk("t1_cnt", cnt1, 1);
        wait_idle1();
        pulse_clr();
        chk("t1_ovr_clr", ovr1, 0);

        // Ten back-to-back samples at the minimum period
        fix_dat = 0; lat1 = 1; en1 = 1;
        wait_vld(10, 80);
        en1 = 0;
        wait_idle1();
        chk("t2_ovr", ovr1, 0);
        chk("t2_cnt", cnt1, exp_cnt1);

        // Spurious rdy while idle must be ignored
        spur1 = 1;
        repeat (4) @(negedge clk);
        spur1 = 0;
        repeat (2) @(negedge clk);
        chk("spur_cnt", cnt1, exp_cnt1);
        chk("spur_busy", busy1, 0);

        // Dead ADC: timeout, ADC re-reset, flag clear
        dead1 = 1; en1 = 1;
        n = 0;
        while (!req1 && n < 20) begin n++; @(negedge clk); end
        en1 = 0;
        n = 0;
        while (req1 && n < 40) begin n++; @(negedge clk); end
        chk("to_req_cycles", n, 16);
        chk("to_err_to", eto1, 1);
        n = 0;
        while (rst1 && n < 20) begin n++; @(negedge clk); end
        chk("to_rst_cycles", n, 4);
        chk("to_cnt_kept", cnt1, exp_cnt1);
        dead1 = 0;
        wait_idle1();
        pulse_clr();
        chk("to_err_clr", eto1, 0);

        // DIV=2 instance with slow ADC: overruns, strobes match handshakes
        en2 = 1;
        repeat (60) @(negedge clk);
        en2 = 0;
        n = 0;
        while (busy2 && n < 40) begin n++; @(negedge clk); end
        chk("t4_ovr", ovr2, 1);
        chk("t4_vld_eq_hs", n_vld2, n_hs2);
        chk("t4_progress", n_vld2 > 5, 1);

        // Sample counter wrap
        force u_dut1.r_smp_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release u_dut1.r_smp_cnt;
        exp_cnt1 = 32'hFFFF_FFFF;
        chk("wrap_pre", cnt1, 32'hFFFF_FFFF);
        en1 = 1;
        wait_vld(1, 40);
        en1 = 0;
        chk("wrap_cnt", cnt1, 0);
        wait_idle1();

        // Asynchronous reset while a request is outstanding
        lat1 = 10; en1 = 1;
        n = 0;
        while (!req1 && n < 20) begin n++; @(negedge clk); end
        chk("t6_req_seen", req1, 1);
        @(posedge clk);
        #2 reset = 1;
        #1;
        chk("t6_adc_req", req1, 0);
        chk("t6_adc_rst", rst1, 1);
        chk("t6_smp_dat", sdat1, 0);
        chk("t6_smp_vld", vld1, 0);
        chk("t6_smp_cnt", cnt1, 0);
        chk("t6_busy", busy1, 1);
        chk("t6_err_to", eto1, 0);
        chk("t6_ovr", ovr1, 0);
        q1.delete();
        exp_cnt1 = '0;
        en1 = 0;
        @(negedge clk);
        reset = 0;
        repeat (8) @(negedge clk);
        chk("t6_recovered", busy1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
